// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - register map, bit positions and FSM encoding for ifft4_periph
package fft_pkg;

   localparam logic [13:0] OFF_IN_COUNT  = 14'd8;
   localparam logic [13:0] OFF_CTRL      = 14'd8;
   localparam logic [13:0] OFF_STATUS    = 14'd9;
   localparam logic [13:0] OFF_OUT_FIRST = 14'd16;
   localparam logic [13:0] OFF_OUT_LAST  = 14'd23;

   localparam int CTRL_START = 0;
   localparam int CTRL_SCALE = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVF  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SUM  = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic [1:0]  we);
      return {we[1] ? new_v[15:8] : old_v[15:8], we[0] ? new_v[7:0] : old_v[7:0]};
   endfunction

   function automatic logic signed [17:0] sx18(input logic [15:0] v);
      return {{2{v[15]}}, v};
   endfunction

endpackage

// File: rtl/ifft4_periph_if.sv
// rtl/ifft4_periph_if.sv - peripheral bus and interrupt bundle for ifft4_periph
interface ifft4_periph_if;
   logic        per_en;
   logic [1:0]  per_we;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic [15:0] per_dout;
   logic        irq_done;

   modport master (
      output per_en, per_we, per_addr, per_din,
      input  per_dout, irq_done
   );

   modport slave (
      input  per_en, per_we, per_addr, per_din,
      output per_dout, irq_done
   );
endinterface

// File: rtl/ibutterfly4.sv
// rtl/ibutterfly4.sv - stateless stage-2 inverse radix-4 combine with scale/saturate
module ibutterfly4 (
   input  logic [17:0] part_i [8],
   input  logic        scale_i,
   output logic [15:0] res_o  [8],
   output logic        ovf_o
);
   // part_i order: A+C (r,i), A-C (r,i), B+D (r,i), B-D (r,i)
   logic signed [17:0] acp_r, acp_i, acm_r, acm_i, bdp_r, bdp_i, bdm_r, bdm_i;
   logic signed [17:0] x [8];

   assign acp_r = $signed(part_i[0]);
   assign acp_i = $signed(part_i[1]);
   assign acm_r = $signed(part_i[2]);
   assign acm_i = $signed(part_i[3]);
   assign bdp_r = $signed(part_i[4]);
   assign bdp_i = $signed(part_i[5]);
   assign bdm_r = $signed(part_i[6]);
   assign bdm_i = $signed(part_i[7]);

   always_comb begin
      x[0] = acp_r + bdp_r;
      x[1] = acp_i + bdp_i;
      x[2] = acm_r - bdm_i;
      x[3] = acm_i + bdm_r;
      x[4] = acp_r - bdp_r;
      x[5] = acp_i - bdp_i;
      x[6] = acm_r + bdm_i;
      x[7] = acm_i - bdm_r;
      ovf_o = 1'b0;
      for (int i = 0; i < 8; i++) begin
         res_o[i] = x[i][17:2];
         if (!scale_i) begin
            if (x[i] > 18'sd32767) begin
               res_o[i] = 16'h7FFF;
               ovf_o    = 1'b1;
            end else if (x[i] < -18'sd32768) begin
               res_o[i] = 16'h8000;
               ovf_o    = 1'b1;
            end else begin
               res_o[i] = x[i][15:0];
            end
         end
      end
   end
endmodule

// File: rtl/ifft4_periph.sv
// rtl/ifft4_periph.sv - memory-mapped 4-point inverse FFT butterfly peripheral
module ifft4_periph
   import fft_pkg::*;
#(
   parameter logic [13:0] BASE_ADDR = 14'h0A0
) (
   input  logic          mclk,
   input  logic          puc_rst_n,
   ifft4_periph_if.slave bus
);

   logic [13:0] off;
   logic        hit, wr, rd, start_req;
   logic [15:0] in_q   [8];
   logic [15:0] snap_q [8];
   logic [17:0] part_d [8];
   logic [17:0] part_q [8];
   logic [15:0] out_q  [8];
   logic [15:0] bf_res [8];
   logic        bf_ovf;
   logic        scale_q, ie_q, snap_scale_q, busy_q, done_q, ovf_q, ovf_pend_q;
   logic [15:0] dout;
   state_t      state_q;

   assign off       = bus.per_addr - BASE_ADDR;
   assign hit       = bus.per_en && (bus.per_addr >= BASE_ADDR);
   assign wr        = hit && (bus.per_we != 2'b00);
   assign rd        = hit && (bus.per_we == 2'b00);
   assign start_req = wr && (off == OFF_CTRL) && bus.per_we[0] && bus.per_din[CTRL_START];

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         for (int i = 0; i < 8; i++) in_q[i] <= '0;
         scale_q <= 1'b0;
         ie_q    <= 1'b0;
      end else if (wr) begin
         if (off < OFF_IN_COUNT)
            in_q[off[2:0]] <= byte_merge(in_q[off[2:0]], bus.per_din, bus.per_we);
         if ((off == OFF_CTRL) && bus.per_we[0]) begin
            scale_q <= bus.per_din[CTRL_SCALE];
            ie_q    <= bus.per_din[CTRL_IE];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         part_d[k]     = sx18(snap_q[k])     + sx18(snap_q[k + 4]);
         part_d[2 + k] = sx18(snap_q[k])     - sx18(snap_q[k + 4]);
         part_d[4 + k] = sx18(snap_q[2 + k]) + sx18(snap_q[6 + k]);
         part_d[6 + k] = sx18(snap_q[2 + k]) - sx18(snap_q[6 + k]);
      end
   end

   ibutterfly4 u_bfly (
      .part_i  (part_q),
      .scale_i (snap_scale_q),
      .res_o   (bf_res),
      .ovf_o   (bf_ovf)
   );

   // W1C is applied before the FSM so a same-cycle DONE/OVF set overrides the clear.
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         ovf_pend_q   <= 1'b0;
         snap_scale_q <= 1'b0;
         snap_q       <= '{default: '0};
         part_q       <= '{default: '0};
         out_q        <= '{default: '0};
      end else begin
         if (wr && (off == OFF_STATUS) && bus.per_we[0]) begin
            if (bus.per_din[STAT_DONE]) done_q <= 1'b0;
            if (bus.per_din[STAT_OVF])  ovf_q  <= 1'b0;
         end
         case (state_q)
            ST_IDLE: if (start_req) begin
               state_q      <= ST_LOAD;
               busy_q       <= 1'b1;
               done_q       <= 1'b0;
               snap_q       <= in_q;
               snap_scale_q <= bus.per_din[CTRL_SCALE];
            end
            ST_LOAD: begin
               part_q  <= part_d;
               state_q <= ST_SUM;
            end
            ST_SUM: begin
               out_q      <= bf_res;
               ovf_pend_q <= bf_ovf;
               state_q    <= ST_OUT;
            end
            ST_OUT: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               if (ovf_pend_q) ovf_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dout = '0;
      if (rd) begin
         if (off < OFF_IN_COUNT) begin
            dout = in_q[off[2:0]];
         end else if (off == OFF_CTRL) begin
            dout[CTRL_SCALE] = scale_q;
            dout[CTRL_IE]    = ie_q;
         end else if (off == OFF_STATUS) begin
            dout[STAT_BUSY] = busy_q;
            dout[STAT_DONE] = done_q;
            dout[STAT_OVF]  = ovf_q;
         end else if ((off >= OFF_OUT_FIRST) && (off <= OFF_OUT_LAST)) begin
            dout = out_q[off[2:0]];
         end
      end
   end

   assign bus.per_dout = dout;
   assign bus.irq_done = done_q & ie_q;

endmodule

// File: tb/tb_ifft4_periph.sv
// tb/tb_ifft4_periph.sv - randomized self-checking bench for ifft4_periph
module tb_ifft4_periph;

   localparam logic [13:0] BASE = 14'h0A0;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          irq_rises = 0;
   logic        irq_prev  = 1'b0;
   logic [15:0] cur_in  [8];
   logic [15:0] exp_out [8];
   logic        exp_ovf;

   ifft4_periph_if bus ();

   ifft4_periph #(.BASE_ADDR(BASE)) dut (
      .mclk      (clk),
      .puc_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      irq_prev <= bus.irq_done;
      if (bus.irq_done && !irq_prev) irq_rises <= irq_rises + 1;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic bus_wr(input logic [13:0] off, input logic [15:0] d, input logic [1:0] we);
      bus.per_addr = BASE + off;
      bus.per_din  = d;
      bus.per_we   = we;
      bus.per_en   = 1'b1;
      @(posedge clk);
      #1;
      bus.per_en = 1'b0;
      bus.per_we = 2'b00;
   endtask

   task automatic bus_rd(input logic [13:0] off, output logic [15:0] d);
      bus.per_addr = BASE + off;
      bus.per_we   = 2'b00;
      bus.per_en   = 1'b1;
      #1;
      d = bus.per_dout;
      bus.per_en = 1'b0;
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 3))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Reference: direct complex formulas on integers, then scale or clamp.
   task automatic model(input bit sc);
      int ar, ai, br, bi, cr, ci, dr, di, v;
      int x [8];
      ar = int'($signed(cur_in[0])); ai = int'($signed(cur_in[1]));
      br = int'($signed(cur_in[2])); bi = int'($signed(cur_in[3]));
      cr = int'($signed(cur_in[4])); ci = int'($signed(cur_in[5]));
      dr = int'($signed(cur_in[6])); di = int'($signed(cur_in[7]));
      x[0] = ar + br + cr + dr;          x[1] = ai + bi + ci + di;
      x[2] = (ar - cr) - (bi - di);      x[3] = (ai - ci) + (br - dr);
      x[4] = (ar + cr) - (br + dr);      x[5] = (ai + ci) - (bi + di);
      x[6] = (ar - cr) + (bi - di);      x[7] = (ai - ci) - (br - dr);
      exp_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (sc) v = x[i] >>> 2;
         else if (x[i] > 32767) begin v = 32767; exp_ovf = 1'b1; end
         else if (x[i] < -32768) begin v = -32768; exp_ovf = 1'b1; end
         else v = x[i];
         exp_out[i] = v[15:0];
      end
   endtask

   task automatic load_in();
      for (int i = 0; i < 8; i++) bus_wr(14'(i), cur_in[i], 2'b11);
   endtask

   task automatic check_outs(input string tag);
      logic [15:0] d;
      for (int i = 0; i < 8; i++) begin
         bus_rd(14'(16 + i), d);
         chk($sformatf("%s_out%0d", tag, i), d, exp_out[i]);
      end
   endtask

   task automatic run(input bit sc, input bit ie, input string tag);
      logic [15:0] d;
      load_in();
      bus_wr(14'd9, 16'h0006, 2'b11);
      bus_wr(14'd8, {13'd0, ie, sc, 1'b1}, 2'b11);
      repeat (2) @(posedge clk);
      #1;
      bus_rd(14'd9, d);
      chk({tag, "_busy"}, d, 16'h0001);
      @(posedge clk);
      #1;
      model(sc);
      bus_rd(14'd9, d);
      chk({tag, "_status"}, d, {13'd0, exp_ovf, 2'b10});
      check_outs(tag);
   endtask

   initial begin
      logic [15:0] d;
      logic [15:0] v2 [8];
      int          base_irq;

      bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = '0; bus.per_din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      bus_rd(14'd9, d);  chk("rst_status", d, 16'h0000);
      bus_rd(14'd8, d);  chk("rst_ctrl", d, 16'h0000);
      bus_rd(14'd0, d);  chk("rst_in_ar", d, 16'h0000);
      bus_rd(14'd16, d); chk("rst_out0r", d, 16'h0000);
      chk("rst_irq", 16'(bus.irq_done), 16'h0000);

      for (int i = 0; i < 8; i++) cur_in[i] = (i % 2 == 0) ? 16'd100 : 16'd0;
      run(1'b1, 1'b0, "unity");
      bus_rd(14'd16, d); chk("unity_out0r_const", d, 16'd100);

      for (int i = 0; i < 8; i++) cur_in[i] = 16'd0;
      cur_in[2] = 16'd4;
      run(1'b0, 1'b0, "b_only");
      bus_rd(14'd19, d); chk("b_only_x1i_const", d, 16'h0004);
      bus_rd(14'd23, d); chk("b_only_x3i_const", d, 16'hFFFC);

      for (int i = 0; i < 8; i++) cur_in[i] = (i % 2 == 0) ? 16'h7FFF : 16'h0000;
      run(1'b0, 1'b0, "sat");
      bus_rd(14'd9, d);  chk("sat_ovf_const", d, 16'h0006);
      run(1'b1, 1'b0, "sat_scaled");
      bus_rd(14'd16, d); chk("sat_scaled_out0r_const", d, 16'h7FFF);

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 8; i++) cur_in[i] = rnd16();
         run(1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", k));
      end

      bus_wr(14'd16, 16'h5555, 2'b11);
      bus_rd(14'd16, d); chk("ro_out_write", d, exp_out[0]);
      bus_wr(14'd12, 16'hFFFF, 2'b11);
      bus_rd(14'd12, d); chk("unmapped_12", d, 16'h0000);
      bus_rd(14'd24, d); chk("unmapped_24", d, 16'h0000);
      bus.per_addr = BASE + 14'd16;
      #1;
      chk("dout_not_selected", bus.per_dout, 16'h0000);

      for (int i = 0; i < 8; i++) cur_in[i] = rnd16();
      load_in();
      bus_wr(14'd9, 16'h0006, 2'b11);
      base_irq = irq_rises;
      bus_wr(14'd8, 16'h0007, 2'b11);
      bus_wr(14'd8, 16'h0005, 2'b11);
      for (int i = 0; i < 8; i++) begin
         v2[i] = rnd16();
         bus_wr(14'(i), v2[i], 2'b11);
      end
      repeat (4) @(posedge clk);
      #1;
      model(1'b1);
      check_outs("busy_snap");
      bus_rd(14'd9, d); chk("busy_snap_status", d, 16'h0002);
      chk("busy_snap_irq_once", 16'(irq_rises - base_irq), 16'd1);
      bus_rd(14'd0, d); chk("busy_in_write", d, v2[0]);
      bus_rd(14'd8, d); chk("busy_ctrl_write", d, 16'h0004);

      chk("irq_set", 16'(bus.irq_done), 16'h0001);
      bus_wr(14'd9, 16'h0002, 2'b11);
      bus_rd(14'd9, d); chk("done_w1c", d, 16'h0000);
      chk("irq_clr", 16'(bus.irq_done), 16'h0000);
      bus_wr(14'd0, 16'h1234, 2'b11);
      bus_wr(14'd0, 16'hABCD, 2'b01);
      bus_rd(14'd0, d); chk("byte_lo", d, 16'h12CD);
      bus_wr(14'd0, 16'hABCD, 2'b10);
      bus_rd(14'd0, d); chk("byte_hi", d, 16'hABCD);

      for (int i = 0; i < 8; i++) cur_in[i] = (i % 2 == 0) ? 16'h7FFF : 16'h0000;
      load_in();
      bus_wr(14'd9, 16'h0006, 2'b11);
      bus_wr(14'd8, 16'h0001, 2'b11);
      repeat (2) @(posedge clk);
      #1;
      bus_wr(14'd9, 16'h0006, 2'b11);
      bus_rd(14'd9, d); chk("set_wins", d, 16'h0006);
      bus_wr(14'd9, 16'h0006, 2'b11);
      bus_rd(14'd9, d); chk("w1c_after", d, 16'h0000);

      for (int i = 0; i < 8; i++) cur_in[i] = rnd16();
      load_in();
      bus_wr(14'd8, 16'h0005, 2'b11);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      bus_rd(14'd9, d); chk("in_rst_status", d, 16'h0000);
      rst_n = 1'b1;
      bus_rd(14'd9, d);  chk("abort_status", d, 16'h0000);
      bus_rd(14'd16, d); chk("abort_out0r", d, 16'h0000);
      bus_rd(14'd0, d);  chk("abort_in_ar", d, 16'h0000);
      bus_rd(14'd8, d);  chk("abort_ctrl", d, 16'h0000);
      chk("abort_irq", 16'(bus.irq_done), 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      bus_rd(14'd9, d);  chk("abort_no_done", d, 16'h0000);

      for (int i = 0; i < 8; i++) cur_in[i] = rnd16();
      run(1'b0, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
